// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 10;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CPU  = 1'b1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester and FIFO-side handshake bundle
interface fifo_write_arbiter_if #(
    parameter int DATA_W = 12
);
    logic [1:0]        req;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [1:0]        ack;
    logic              cons_adv;
    logic              fifo_write;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rst;

    modport master (
        output req, data0, data1, cons_adv,
        input  ack, fifo_write, fifo_data, fifo_rst
    );

    modport slave (
        input  req, data0, data1, cons_adv,
        output ack, fifo_write, fifo_data, fifo_rst
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_arb2.sv
// rtl/fifo_write_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2
    import fifo_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       rr_last,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    // On contention the requester that did not win last time goes next.
    always_comb begin
        gnt_valid = |eligible;
        if (&eligible) begin
            gnt_idx = ~rr_last;
        end else if (eligible[REQ_CPU]) begin
            gnt_idx = REQ_CPU;
        end else begin
            gnt_idx = REQ_HOST;
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - FIFO write-port arbiter with occupancy tracking and flush; FIFO_ARB_STATS_EN adds write/stall counters
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_write_arbiter_if.slave bus,
    input  logic              flush,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              overflow
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]       wr_cnt0,
    output logic [15:0]       wr_cnt1,
    output logic [15:0]       stall_cnt
`endif
);
    localparam logic [ADDR_W-1:0] CAP = {ADDR_W{1'b1}};
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic            rr_last;
    logic [1:0]      eligible;
    logic            gnt_valid;
    logic            gnt_idx;
    logic            pop;

    assign full  = (count == CAP);
    assign empty = (count == '0);

    // Masking with ack stops a requester being granted again while it still sees its ack.
    assign eligible = bus.req & ~bus.ack & {2{~full}};
    assign pop      = bus.cons_adv && !empty;

    rr_arb2 u_rr_arb2 (
        .eligible  (eligible),
        .rr_last   (rr_last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            flush_cnt      <= '0;
            rr_last        <= 1'b1;
            bus.ack        <= '0;
            bus.fifo_write <= 1'b0;
            bus.fifo_data  <= '0;
            bus.fifo_rst   <= 1'b0;
            count          <= '0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        state          <= FLUSH;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
                        bus.fifo_rst   <= 1'b1;
                        bus.ack        <= '0;
                        bus.fifo_write <= 1'b0;
                        count          <= '0;
                        overflow       <= 1'b0;
                    end else begin
                        bus.ack        <= '0;
                        bus.fifo_write <= gnt_valid;
                        if (gnt_valid) begin
                            bus.ack[gnt_idx] <= 1'b1;
                            bus.fifo_data    <= gnt_idx ? bus.data1 : bus.data0;
                            rr_last          <= gnt_idx;
                        end
                        if ((bus.req != 2'b00) && full) begin
                            overflow <= 1'b1;
                        end
                        count <= count + ADDR_W'(gnt_valid) - ADDR_W'(pop);
                    end
                end
                FLUSH: begin
                    bus.ack        <= '0;
                    bus.fifo_write <= 1'b0;
                    count          <= '0;
                    if (flush_cnt == '0) begin
                        bus.fifo_rst <= 1'b0;
                        state        <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic grant_eff;
    assign grant_eff = (state == RUN) && !flush && gnt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt0   <= '0;
            wr_cnt1   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state == RUN) && flush) begin
                wr_cnt0 <= '0;
                wr_cnt1 <= '0;
            end else if (grant_eff) begin
                if (gnt_idx) wr_cnt1 <= wr_cnt1 + 16'd1;
                else         wr_cnt0 <= wr_cnt0 + 16'd1;
            end
            if ((state == RUN) && (bus.req != 2'b00) && !grant_eff && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench with a cycle-level reference model
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int DW  = 12;
    localparam int AW  = 10;
    localparam int FC  = 4;
    localparam int CAP = 1023;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    fifo_write_arbiter_if #(.DATA_W(DW)) bus ();

    fifo_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit compare_on = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs derived from the arbitration/occupancy rules.
    bit        m_flushing = 0;
    int        m_left     = 0;
    bit [1:0]  m_ack      = 0;
    bit        m_wr       = 0;
    bit [DW-1:0] m_data   = 0;
    bit        m_rst      = 0;
    int        m_count    = 0;
    bit        m_ovf      = 0;
    int        m_last     = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flushing = 0; m_left = 0; m_ack = 0; m_wr = 0; m_data = 0;
            m_rst = 0; m_count = 0; m_ovf = 0; m_last = 1;
        end else if (m_flushing) begin
            m_ack = 0; m_wr = 0; m_count = 0;
            if (m_left == 0) begin
                m_flushing = 0; m_rst = 0;
            end else begin
                m_left--;
            end
        end else if (flush) begin
            m_flushing = 1; m_rst = 1; m_left = FC - 1;
            m_ack = 0; m_wr = 0; m_count = 0; m_ovf = 0;
        end else begin
            bit is_full;
            bit e0, e1;
            int g;
            is_full = (m_count == CAP);
            e0 = bus.req[0] && !m_ack[0] && !is_full;
            e1 = bus.req[1] && !m_ack[1] && !is_full;
            g = -1;
            if (e0 && e1) g = 1 - m_last;
            else if (e0) g = 0;
            else if (e1) g = 1;
            if (bus.req != 0 && is_full) m_ovf = 1;
            if (bus.cons_adv && m_count > 0) m_count--;
            m_ack = 0;
            m_wr  = (g >= 0);
            if (g >= 0) begin
                m_ack[g] = 1;
                m_data   = (g == 1) ? bus.data1 : bus.data0;
                m_last   = g;
                m_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check("model_cycle",
                  {bus.ack, bus.fifo_write, bus.fifo_data, bus.fifo_rst, count, full, empty, overflow},
                  {m_ack, m_wr, m_data, m_rst, AW'(m_count), m_count == CAP, m_count == 0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0;
        bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0; bus.cons_adv = 1'b0;
        repeat (3) tick();
        compare_on = 1;
        rst_n = 1'b1;
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_ack", bus.ack, 0);
        check("reset_fifo_rst", bus.fifo_rst, 0);

        // Single write from requester 0
        bus.req = 2'b01; bus.data0 = 12'h123;
        tick();
        check("first_ack", bus.ack, 2'b01);
        check("first_write", bus.fifo_write, 1);
        check("first_data", bus.fifo_data, 12'h123);
        tick();
        check("no_double_write", bus.fifo_write, 0);
        check("count_after_one", count, 1);
        bus.req = 2'b00;
        tick();

        // Contention: alternation starting with requester 1 (requester 0 won last)
        bus.req = 2'b11; bus.data0 = 12'h0A0; bus.data1 = 12'h0B1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("alt_ack", bus.ack, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("alt_data", bus.fifo_data, (k % 2 == 0) ? 12'h0B1 : 12'h0A0);
        end
        check("alt_count", count, 9);
        bus.req = 2'b00;
        tick();

        // Fill to capacity through requester 0
        bus.req = 2'b01; bus.data0 = 12'h5A5;
        for (int i = 0; i < 5000 && !full; i++) tick();
        check("fill_full", full, 1);
        check("fill_count", count, CAP);
        tick();
        check("full_overflow", overflow, 1);
        check("full_no_ack", bus.ack, 0);
        bus.cons_adv = 1'b1;
        tick();
        bus.cons_adv = 1'b0;
        check("pop_count", count, 1022);
        check("pop_not_full", full, 0);
        tick();
        check("refill_ack", bus.ack, 2'b01);
        check("refill_count", count, CAP);
        bus.req = 2'b00;

        // Flush clears occupancy and overflow
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ovf_clear", overflow, 0);
        check("flush_count_zero", count, 0);
        repeat (5) tick();

        // Build count 5, then push+pop in one cycle
        bus.req = 2'b01;
        for (int i = 0; i < 100 && count != 5; i++) tick();
        bus.req = 2'b00;
        tick();
        check("pre_count5", count, 5);
        bus.req = 2'b01; bus.cons_adv = 1'b1;
        tick();
        bus.req = 2'b00; bus.cons_adv = 1'b0;
        check("pushpop_ack", bus.ack, 2'b01);
        check("pushpop_count", count, 5);
        bus.cons_adv = 1'b1;
        for (int i = 0; i < 20 && count != 0; i++) tick();
        tick();
        bus.cons_adv = 1'b0;
        check("pop_empty_count", count, 0);
        check("pop_empty_flag", empty, 1);

        // count 7, requester 1 waiting, flush in same cycle
        bus.req = 2'b01;
        for (int i = 0; i < 100 && count != 7; i++) tick();
        bus.req = 2'b00;
        tick();
        check("pre_count7", count, 7);
        bus.req = 2'b10; bus.data1 = 12'h777; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_suppress_ack", bus.ack, 0);
        check("flush_rst_high", bus.fifo_rst, 1);
        check("flush_count", count, 0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.fifo_rst) n++;
            else break;
        end
        check("flush_len", n, FC);
        check("flush_exit_no_ack", bus.ack, 0);
        tick();
        check("post_flush_ack", bus.ack, 2'b10);
        check("post_flush_data", bus.fifo_data, 12'h777);
        bus.req = 2'b00;
        tick();

        // Asynchronous reset in the middle of a flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("mid_flush_rst_high", bus.fifo_rst, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_fifo_rst", bus.fifo_rst, 0);
        check("async_ack", bus.ack, 0);
        check("async_write", bus.fifo_write, 0);
        tick();
        rst_n = 1'b1;
        bus.req = 2'b11;
        tick();
        check("post_reset_rr", bus.ack, 2'b01);
        bus.req = 2'b00;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of one 12-bit I/O FIFO between two requesters: host test-data loader (requester 0) and CPU output path (requester 1).
- Tracks FIFO occupancy, since the FIFO itself has no flags, and exposes full/empty/count.
- Sequences a flush: holds the FIFO in reset for a fixed number of cycles, then resumes.
- Sits between the requesters and the FIFO's data_write / data_in / rst inputs. It also snoops the consumer's data_adv.

Parameters:
- DATA_W, 12, data width of the FIFO word.
- ADDR_W, 10, FIFO address width; usable capacity is 2**ADDR_W - 1 = 1023 entries.
- FLUSH_CYCLES, 4, number of cycles fifo_rst is held high during a flush; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester write request; the requester holds it with stable data until acked.
- data0  in  DATA_W  requester 0 write data.
- data1  in  DATA_W  requester 1 write data.
- ack  out  2  one-cycle pulse per requester; its write has been issued.
- cons_adv  in  1  copy of the consumer's data_adv to the FIFO.
- flush  in  1  one-cycle pulse to request a FIFO flush.
- fifo_write  out  1  drives FIFO data_write.
- fifo_data  out  DATA_W  drives FIFO data_in.
- fifo_rst  out  1  drives FIFO rst (active-high, synchronous at the FIFO).
- count  out  ADDR_W  current occupancy.
- full  out  1  high when count == 2**ADDR_W-1.
- empty  out  1  high when count == 0.
- overflow  out  1  sticky; set when req is seen while full; cleared only by reset or flush.

Behaviour:
- Reset, rst_n low, asynchronous:
  - state=RUN, ack=0, fifo_write=0, fifo_data=0, fifo_rst=0.
  - count=0, overflow=0, rr_last=1, so requester 0 wins first.
- States: RUN, FLUSH.
- RUN, grant evaluation each cycle:
  - eligible[i] = req[i] && !ack[i] && !full.
  - The !ack[i] term prevents a double grant while the requester is still seeing its ack.
  - If both requesters are eligible, grant the one not equal to rr_last. If one is eligible, grant it.
- On a grant to requester g, all registered at the same edge:
  - fifo_write<=1, fifo_data<=data_g, ack[g]<=1, rr_last<=g.
  - Write latency: request sampled at edge N; write and ack visible in cycle N+1.
- With no grant: fifo_write<=0, ack<=0, and fifo_data holds its value.
- Occupancy:
  - push = grant this cycle.
  - pop = cons_adv && count!=0. This mirrors the FIFO rule that it advances only when not empty.
  - count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
  - count is never incremented past full and never decremented below 0.
- overflow <= 1 when (req!=0 && full) in RUN.
- Flush accepted in RUN:
  - Next state FLUSH; fifo_rst<=1; load a down-counter with FLUSH_CYCLES-1.
  - A grant evaluated in the same cycle as flush is suppressed: no ack, no write.
- FLUSH:
  - No grants; ack=0, fifo_write=0.
  - count forced to 0 and overflow cleared on entry.
  - cons_adv is ignored.
  - When the down-counter reaches 0: fifo_rst<=0 and state returns to RUN.
  - A flush pulse arriving while in FLUSH is ignored.
- Requester side: req may drop at any time before ack with no side effects. Data must stay stable while req is high.
- Reset asserted mid-flush aborts the flush immediately; all outputs take reset values.

Optional Feature:
- FIFO_ARB_STATS_EN defined:
  - Adds outputs wr_cnt0 and wr_cnt1, 16 bits each, counting acked writes per requester.
  - Both wrap at 2**16, clear on reset and on flush entry.
  - Adds a stall_cnt output, 16 bits, saturating, that counts cycles with req!=0 and no grant in RUN.
- FIFO_ARB_STATS_EN undefined: these ports and their logic are absent.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {RUN, FLUSH}.
  - DATA_W and ADDR_W default constants.
  - requester index constants REQ_HOST=0, REQ_CPU=1.
- One natural sub-module, rr_arb2: a 2-way round-robin picker. Inputs are eligible[1:0] and rr_last; outputs are grant valid and grant index. It is purely combinational.
- Occupancy, flush FSM and stats stay in the top level.

Test Plan:
- Reset then req=01, data0=0x123 held:
  - ack[0] and fifo_write pulse in the next cycle with fifo_data=0x123.
  - No second write until req is re-evaluated after ack drops; count=1.
- req=11 held continuously:
  - Writes alternate 0,1,0,1 with one write per cycle.
  - Neither ack is high in two consecutive cycles; count rises by 1 per cycle.
- Fill via requester 0 until count=1023:
  - full=1, no further acks.
  - overflow=1 on the next cycle with req high.
  - A single cons_adv gives count=1022, full=0, and one more write is granted.
- count=5, grant and cons_adv in the same cycle:
  - count stays 5.
  - With count=0 and cons_adv=1, count stays 0.
- count=7, req=10, flush pulse:
  - No ack that cycle; fifo_rst high for exactly 4 cycles.
  - count=0 and overflow=0 during flush.
  - First grant occurs in the cycle after fifo_rst falls.
- rst_n asserted low mid-flush:
  - fifo_rst, ack and fifo_write go to 0 immediately, without waiting for a clock edge.
  - After release, requester 0 wins the first contended grant.
